md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Execute-stage multiply/divide unit. It consumes the IR/RS/RT operands latched by the E pipeline register and owns the HI/LO registers. It models fixed multi-cycle latency for mult/multu/div/divu and drives md_stall back to the hazard unit. The hazard unit uses md_stall to freeze D and bubble E (the m_stall path into the E register).

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
md_start  input  1  E-stage instruction is a valid md op this cycle
md_op  input  3  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo; others = no-op
rs_in  input  32  forwarded RS operand (E stage)
rt_in  input  32  forwarded RT operand (E stage)
d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
hi_out  output  32  HI register
lo_out  output  32  LO register
busy  output  1  multi-cycle operation in progress
md_stall  output  1  request to stall D / bubble E

Behaviour:
- Reset (reset=0, async): hi_out=0, lo_out=0, busy=0, counter=0, pending results=0. Takes effect immediately, including mid-operation. The in-flight op is discarded and HI/LO are not written.
- States: IDLE (busy=0) and RUN (busy=1). The counter is internal and its width fits max(MULT_CYCLES, DIV_CYCLES).
- IDLE, md_start=1, op 1-4, edge T:
  - Compute the 64-bit result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 from T+1.
- mult: signed 32x32 product, {hi,lo} = 64-bit product.
- multu: unsigned 32x32 product, {hi,lo} = 64-bit product.
- div: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (rt_in=0, op 3/4): runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- RUN: counter decrements each edge. On the edge where counter==1: HI/LO <= pending, busy <= 0. Result is visible the cycle busy is first low. busy is therefore high for exactly N cycles.
- mthi/mtlo (op 5/6) in IDLE: hi or lo <= rs_in at that edge; busy never rises.
- md_start while busy=1: ignored, no state change. Hazard logic guarantees this does not occur; the bench checks that it is ignored.
- No-op encodings (0, 7) with md_start=1: ignored.
- hi_out/lo_out are register outputs (mfhi/mflo read them). During RUN they hold the pre-op values.
- md_stall = d_is_md & (busy | (md_start & md_op in 1..4)). This is combinational, so it is asserted in the start cycle as well.
- Operands are sampled only at the start edge. Later rs_in/rt_in changes have no effect.

Test Plan:
- reset=0 mid-RUN of mult (3rd busy cycle) -> busy=0, hi=lo=0 immediately. After release, hi/lo stay 0 until the next op.
- mult, rs=0xFFFFFFFF, rt=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div, rs=0xFFFFFFF9 (-7), rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, rs=7, rt=2 -> lo=3, hi=1.
- Set hi=0x12345678 via mthi, then div with rt=0 -> busy 10 cycles, hi stays 0x12345678 and lo is unchanged afterwards.
- md_stall: d_is_md=1 with mult start -> md_stall=1 from the start cycle through the last busy cycle, then 0. d_is_md=0 -> md_stall=0 throughout.
- mtlo rs=0xCAFEBABE -> lo=0xCAFEBABE next cycle, busy stays 0. md_start with op=1 during RUN -> counter and pending values unaffected.

Source files
------------

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, models fixed multi-cycle
// latency for mult/multu/div/divu and requests D-stall / E-bubble while busy.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  input  logic        d_is_md,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          commit_q, commit_d;
  logic          long_op;

  logic [63:0]        rs_sx, rt_sx, rs_zx, rt_zx, prod_s, prod_u;
  logic signed [31:0] rs_s, rt_s, quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               rt_zero;

  assign rs_sx  = {{32{rs_in[31]}}, rs_in};
  assign rt_sx  = {{32{rt_in[31]}}, rt_in};
  assign rs_zx  = {32'd0, rs_in};
  assign rt_zx  = {32'd0, rt_in};
  // Low 64 bits of a 64x64 product of extended operands give the exact 32x32 result.
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = rs_zx * rt_zx;

  assign rt_zero = (rt_in == '0);
  assign rs_s    = rs_in;
  assign rt_s    = rt_in;
  assign quot_s  = rt_zero ? 32'sd0 : rs_s / rt_s;
  assign rem_s   = rt_zero ? 32'sd0 : rs_s % rt_s;
  assign quot_u  = rt_zero ? 32'd0 : rs_in / rt_in;
  assign rem_u   = rt_zero ? 32'd0 : rs_in % rt_in;

  assign long_op = (md_op >= 3'd1) && (md_op <= 3'd4);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    commit_d  = commit_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            3'd1: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              count_d  = CW'(MULT_CYCLES);
              commit_d = 1'b1;
              state_d  = RUN;
            end
            3'd2: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              count_d  = CW'(MULT_CYCLES);
              commit_d = 1'b1;
              state_d  = RUN;
            end
            3'd3: begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              count_d   = CW'(DIV_CYCLES);
              commit_d  = !rt_zero;
              state_d   = RUN;
            end
            3'd4: begin
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              count_d   = CW'(DIV_CYCLES);
              commit_d  = !rt_zero;
              state_d   = RUN;
            end
            3'd5: hi_d = rs_in;
            3'd6: lo_d = rs_in;
            default: ;
          endcase
        end
      end
      RUN: begin
        // New starts are ignored here; divide-by-zero skips the HI/LO write.
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          if (commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      commit_q  <= commit_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q == RUN);
  assign md_stall = d_is_md & (busy | (md_start & long_op));

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO pushed at op start, popped and
// compared when busy drops; latency, stall and reset behaviour checked inline.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] rs_in, rt_in;
  logic        d_is_md;
  logic [31:0] hi_out, lo_out;
  logic        busy, md_stall;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mhi = '0, mlo = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
    .rs_in(rs_in), .rt_in(rt_in), .d_is_md(d_is_md),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Runs one long op; inject=1 fires an extra mult start mid-run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit inject, input string name);
    logic [63:0] exp;
    int n;
    bit stall_bad, hold_bad;
    sb_q.push_back({exp_hi, exp_lo});
    stall_bad = 0;
    hold_bad = 0;
    @(negedge clk);
    md_start = 1'b1; md_op = op; rs_in = a; rt_in = b;
    #1 if (md_stall !== d_is_md) stall_bad = 1;
    @(negedge clk);
    md_start = 1'b0; rs_in = $urandom; rt_in = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (md_stall !== d_is_md) stall_bad = 1;
      if (hi_out !== mhi || lo_out !== mlo) hold_bad = 1;
      if (inject && n == 1) begin
        md_start = 1'b1; md_op = 3'd1; rs_in = 32'h0000_0005; rt_in = 32'h0000_0007;
      end else begin
        md_start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    md_start = 1'b0;
    if (md_stall !== 1'b0) stall_bad = 1;
    vectors++;
    if (n != cycles) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, cycles);
    end
    vectors++;
    if (stall_bad || hold_bad) begin
      miscompares++;
      $display("FAIL %s stall/hold: stall_bad=%0d hold_bad=%0d expected 0 0", name, stall_bad, hold_bad);
    end
    exp = sb_q.pop_front();
    vectors++;
    if ({hi_out, lo_out} !== exp) begin
      miscompares++;
      $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, hi_out, lo_out, exp[63:32], exp[31:0]);
    end
    mhi = exp[63:32];
    mlo = exp[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b0; md_start = 1'b0; md_op = '0; rs_in = '0; rt_in = '0; d_is_md = 1'b0;
    #12;
    vectors++;
    if ({busy, hi_out, lo_out} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) begin md_start = 1'b1; md_op = 3'd5; rs_in = 32'hAAAA_5555; end
    @(negedge clk) begin md_op = 3'd6; rs_in = 32'h5555_AAAA; end
    @(negedge clk) begin md_op = 3'd1; rs_in = 32'd3; rt_in = 32'd4; end
    @(negedge clk) md_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || hi_out !== 32'hAAAA_5555 || lo_out !== 32'h5555_AAAA) begin
      miscompares++;
      $display("FAIL pre_reset_run: busy=%b hi=%h lo=%h expected 1 aaaa5555 5555aaaa", busy, hi_out, lo_out);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, hi_out, lo_out} !== 65'd0) begin
      miscompares++;
      $display("FAIL mid_run_reset: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
    end
    @(negedge clk) reset = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if ({busy, hi_out, lo_out} !== 65'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi_out, lo_out);
    end
    mhi = '0;
    mlo = '0;
  endtask

  task automatic test_mult();
    d_is_md = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mult_neg1x2");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE, 0, "multu_max_x2");
    run_op(3'd1, 32'h0000_0003, 32'hFFFF_FFFC, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 0, "mult_3x_neg4");
    run_op(3'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000, 0, "multu_carry");
  endtask

  task automatic test_div();
    d_is_md = 1'b0;
    run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg7_2");
    run_op(3'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003, 0, "divu_7_2");
    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 0, "div_7_neg2");
    run_op(3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'h0000_0003, 0, "div_neg7_neg2");
    run_op(3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF, 0, "divu_max_16");
  endtask

  task automatic test_mt();
    d_is_md = 1'b1;
    @(negedge clk);
    md_start = 1'b1; md_op = 3'd6; rs_in = 32'hCAFE_BABE;
    #1;
    vectors++;
    if (md_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo_stall: got %b expected 0", md_stall);
    end
    @(negedge clk);
    md_start = 1'b0;
    vectors++;
    if (lo_out !== 32'hCAFE_BABE || busy !== 1'b0 || hi_out !== mhi) begin
      miscompares++;
      $display("FAIL mtlo: lo=%h busy=%b hi=%h expected cafebabe 0 %h", lo_out, busy, hi_out, mhi);
    end
    mlo = 32'hCAFE_BABE;
    @(negedge clk);
    md_start = 1'b1; md_op = 3'd5; rs_in = 32'h1234_5678;
    @(negedge clk);
    md_start = 1'b0;
    vectors++;
    if (hi_out !== 32'h1234_5678 || busy !== 1'b0 || lo_out !== mlo) begin
      miscompares++;
      $display("FAIL mthi: hi=%h busy=%b lo=%h expected 12345678 0 %h", hi_out, busy, lo_out, mlo);
    end
    mhi = 32'h1234_5678;
  endtask

  task automatic test_div_zero();
    d_is_md = 1'b0;
    run_op(3'd3, 32'h0000_0064, 32'h0000_0000, 10, mhi, mlo, 0, "div_by_zero");
    run_op(3'd4, 32'hDEAD_BEEF, 32'h0000_0000, 10, mhi, mlo, 0, "divu_by_zero");
  endtask

  task automatic test_stall();
    d_is_md = 1'b1;
    run_op(3'd1, 32'h0000_0010, 32'h0000_0010, 5, 32'h0000_0000, 32'h0000_0100, 0, "stall_mult");
    run_op(3'd4, 32'h0000_0064, 32'h0000_0007, 10, 32'h0000_0002, 32'h0000_000E, 0, "stall_divu");
    d_is_md = 1'b0;
    run_op(3'd2, 32'h0000_0002, 32'h0000_0003, 5, 32'h0000_0000, 32'h0000_0006, 0, "nostall_multu");
  endtask

  task automatic test_back_to_back();
    d_is_md = 1'b1;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001, 1, "ignore_start_mult");
    run_op(3'd3, 32'h0000_0011, 32'h0000_0005, 10, 32'h0000_0002, 32'h0000_0003, 1, "ignore_start_div");
  endtask

  task automatic test_noop();
    d_is_md = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      md_start = 1'b1; md_op = (k == 0) ? 3'd0 : 3'd7; rs_in = 32'h0BAD_F00D; rt_in = 32'h3;
      #1;
      vectors++;
      if (md_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL noop_stall op=%0d: got %b expected 0", md_op, md_stall);
      end
      @(negedge clk);
      md_start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || hi_out !== mhi || lo_out !== mlo) begin
        miscompares++;
        $display("FAIL noop op=%0d: busy=%b hi=%h lo=%h expected 0 %h %h", k == 0 ? 0 : 7, busy, hi_out, lo_out, mhi, mlo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_div_zero();
    test_stall();
    test_back_to_back();
    test_noop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
